fp_layer_param_loader: RTL and testbench
========================================

Name: fp_layer_param_loader

Overview:
- Writer side of the parallel parameter interface that fp_mlp_layer consumes (layer_weights, lut_addrs).
- Accepts a serial valid/ready stream of DATA_WIDTH words from the host/DMA path and assembles them into a shadow buffer.
- Atomically commits the shadow buffer to the parallel output buses, so the layer never sees a partially updated weight set.

Parameters:
- DATA_WIDTH, 16, width of one weight word and one stream word.
- N_INPUTS, 4, weights per neuron.
- N_NEURONS, 4, neurons per layer.
- ADDR_WIDTH, 8, width of one per-neuron LUT address (ADDR_WIDTH <= DATA_WIDTH).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- load_start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- load_abort  in  1  cancels an in-progress load; honoured only in LOAD.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  DATA_WIDTH  stream word.
- s_last  in  1  marks final word of a load.
- layer_weights  out  DATA_WIDTH*N_INPUTS*N_NEURONS  active weights, feeds the layer directly.
- lut_addrs  out  ADDR_WIDTH*N_NEURONS  active per-neuron LUT addresses.
- params_valid  out  1  at least one load has committed since reset.
- commit  out  1  one-cycle pulse when new active parameters appear.
- load_busy  out  1  high in LOAD or COMMIT.
- load_error  out  1  sticky framing error; cleared by the next accepted load_start.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; word counter 0.
  - Outputs: layer_weights=0, lut_addrs=0, shadow=0, params_valid=0, commit=0, load_busy=0, load_error=0, s_ready=0.
- Stream order and placement. Each load is N_NEURONS*(N_INPUTS+1) words (20 at defaults). Neuron-major; for neuron i:
  - Words 0..N_INPUTS-1 are weights j. Weight j of neuron i goes to bits [(i*N_INPUTS+j)*DATA_WIDTH +: DATA_WIDTH].
  - Word N_INPUTS is the LUT address. Its s_data[ADDR_WIDTH-1:0] goes to lut_addrs[i*ADDR_WIDTH +: ADDR_WIDTH]; upper bits are ignored.
- Counters:
  - Neuron index 0..N_NEURONS-1 and word-in-neuron index 0..N_INPUTS.
  - Both advance only on a handshake (s_valid & s_ready).
  - Word index wraps to 0 after N_INPUTS and the neuron index increments.
- IDLE:
  - s_ready=0.
  - load_start=1 → LOAD. Counters cleared, load_error cleared, load_busy=1 from the next cycle.
  - Shadow is not cleared.
- LOAD:
  - s_ready=1 combinationally (state == LOAD).
  - Each handshake writes its shadow slot.
  - load_start is ignored.
- Final word (last LUT address word) handshake:
  - With s_last=1 → COMMIT.
  - With s_last=0 → load_error=1, → IDLE, active outputs unchanged.
- s_last=1 on any earlier handshake: load_error=1, → IDLE, active unchanged, that word discarded.
- load_abort=1 in LOAD: → IDLE with no error and active unchanged. It takes priority over a simultaneous handshake, whose word is discarded (s_ready stays 1 that cycle, but the word has no effect).
- COMMIT (exactly one cycle):
  - At the edge ending COMMIT, active ← shadow, commit=1 for one cycle, params_valid=1, → IDLE.
  - Net latency: final handshake at edge E; new layer_weights/lut_addrs and commit visible after edge E+1.
  - load_abort is ignored in COMMIT.
- load_busy is high in LOAD and COMMIT. It drops together with the commit pulse becoming visible, i.e. load_busy=0 in the same cycle commit=1.
- load_start during the commit pulse cycle (state IDLE) is accepted normally: back-to-back loads are allowed.
- Reset mid-load: everything returns to reset values, including active outputs.
- Active outputs are registered and change only at commit; there is no combinational path from s_data to layer_weights.

Test Plan:
- Reset, then load_start and 20 words with s_data = 0x0100+k (k=0..19), s_last on k=19, s_valid continuous:
  - Neuron 0 weights 0x0100..0x0103 and lut_addrs[7:0]=0x04.
  - Neuron 3 weights 0x010F..0x0112 and lut_addrs[31:24]=0x13.
  - commit high one cycle, params_valid=1, load_error=0.
- Same load with s_valid toggling every other cycle → identical final outputs; commit occurs exactly one edge after the 20th handshake.
- After a good load, a second load with s_last asserted on word 10:
  - load_error=1, state IDLE, layer_weights/lut_addrs still equal the first load, commit never pulses.
- Load with s_last=0 on word 19 → load_error=1, active unchanged. The next load_start clears load_error and a correct load commits.
- load_abort asserted together with the handshake of word 7 → IDLE, no error, active unchanged. A following full load commits and word 7 holds the new value.
- rst=0 asserted asynchronously mid-load (word 12, after a prior commit):
  - All outputs immediately 0 and params_valid=0.
  - After release, s_ready=0 until load_start.

Source files
------------

// File: rtl/fp_layer_param_loader.sv
// Parameter loader for fp_mlp_layer: assembles a serial valid/ready word stream
// into a shadow buffer and commits it atomically to the parallel weight/LUT buses.
module fp_layer_param_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int N_INPUTS   = 4,
  parameter int N_NEURONS  = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load_start,
  input  logic                                  load_abort,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [DATA_WIDTH-1:0]                 s_data,
  input  logic                                  s_last,
  output logic [DATA_WIDTH*N_INPUTS*N_NEURONS-1:0] layer_weights,
  output logic [ADDR_WIDTH*N_NEURONS-1:0]       lut_addrs,
  output logic                                  params_valid,
  output logic                                  commit,
  output logic                                  load_busy,
  output logic                                  load_error
);

  localparam int WW = (N_INPUTS > 0) ? $clog2(N_INPUTS + 1) : 1;
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WW-1:0] word_idx;
  logic [NW-1:0] neuron_idx;
  logic [DATA_WIDTH*N_INPUTS*N_NEURONS-1:0] shadow_w;
  logic [ADDR_WIDTH*N_NEURONS-1:0]          shadow_a;

  logic hs;
  logic is_final;
  logic shadow_we;
  logic advance;
  logic err_set;
  logic clr;

  assign s_ready   = (state == LOAD);
  assign load_busy = (state != IDLE);
  assign hs        = s_valid & s_ready;
  assign is_final  = (neuron_idx == NW'(N_NEURONS - 1)) && (word_idx == WW'(N_INPUTS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Abort outranks a coincident handshake; any framing fault discards the word.
  always_comb begin
    state_nx  = state;
    shadow_we = 1'b0;
    advance   = 1'b0;
    err_set   = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nx = LOAD;
          clr      = 1'b1;
        end
      end
      LOAD: begin
        if (load_abort) begin
          state_nx = IDLE;
        end else if (hs) begin
          if (is_final && s_last) begin
            shadow_we = 1'b1;
            state_nx  = COMMIT;
          end else if (is_final || s_last) begin
            err_set  = 1'b1;
            state_nx = IDLE;
          end else begin
            shadow_we = 1'b1;
            advance   = 1'b1;
          end
        end
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_idx      <= '0;
      neuron_idx    <= '0;
      shadow_w      <= '0;
      shadow_a      <= '0;
      layer_weights <= '0;
      lut_addrs     <= '0;
      params_valid  <= 1'b0;
      commit        <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      commit <= (state == COMMIT);

      if (clr) begin
        word_idx   <= '0;
        neuron_idx <= '0;
        load_error <= 1'b0;
      end else begin
        if (err_set) load_error <= 1'b1;
        if (advance) begin
          if (word_idx == WW'(N_INPUTS)) begin
            word_idx   <= '0;
            neuron_idx <= neuron_idx + NW'(1);
          end else begin
            word_idx <= word_idx + WW'(1);
          end
        end
      end

      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        for (int unsigned j = 0; j < N_INPUTS; j++) begin
          if (shadow_we && neuron_idx == NW'(i) && word_idx == WW'(j))
            shadow_w[(i*N_INPUTS+j)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
        end
        if (shadow_we && neuron_idx == NW'(i) && word_idx == WW'(N_INPUTS))
          shadow_a[i*ADDR_WIDTH +: ADDR_WIDTH] <= s_data[ADDR_WIDTH-1:0];
      end

      if (state == COMMIT) begin
        layer_weights <= shadow_w;
        lut_addrs     <= shadow_a;
        params_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_layer_param_loader.sv
// Directed + randomized bench for fp_layer_param_loader against an array-based
// model of the active weight/LUT sets.
module tb_fp_layer_param_loader;

  localparam int DW = 16;
  localparam int NI = 4;
  localparam int NN = 4;
  localparam int AW = 8;
  localparam int NWORDS = NN * (NI + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   load_start;
  logic                   load_abort;
  logic                   s_valid;
  logic                   s_ready;
  logic [DW-1:0]          s_data;
  logic                   s_last;
  logic [DW*NI*NN-1:0]    layer_weights;
  logic [AW*NN-1:0]       lut_addrs;
  logic                   params_valid;
  logic                   commit;
  logic                   load_busy;
  logic                   load_error;

  fp_layer_param_loader #(
    .DATA_WIDTH(DW),
    .N_INPUTS  (NI),
    .N_NEURONS (NN),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_abort   (load_abort),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .layer_weights(layer_weights),
    .lut_addrs    (lut_addrs),
    .params_valid (params_valid),
    .commit       (commit),
    .load_busy    (load_busy),
    .load_error   (load_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: active parameters as a neuron x input table plus a LUT array.
  logic [DW-1:0] exp_w [NN][NI];
  logic [AW-1:0] exp_a [NN];
  logic          exp_pv;
  logic [DW-1:0] words [NWORDS];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW*NI*NN-1:0] flat_w();
    logic [DW*NI*NN-1:0] f = '0;
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NI; j++)
        f[(i*NI+j)*DW +: DW] = exp_w[i][j];
    return f;
  endfunction

  function automatic logic [AW*NN-1:0] flat_a();
    logic [AW*NN-1:0] f = '0;
    for (int i = 0; i < NN; i++) f[i*AW +: AW] = exp_a[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NN; i++) begin
      for (int j = 0; j < NI; j++) exp_w[i][j] = '0;
      exp_a[i] = '0;
    end
    exp_pv = 1'b0;
  endtask

  task automatic model_commit();
    for (int i = 0; i < NN; i++) begin
      for (int j = 0; j < NI; j++) exp_w[i][j] = words[i*(NI+1)+j];
      exp_a[i] = words[i*(NI+1)+NI][AW-1:0];
    end
    exp_pv = 1'b1;
  endtask

  task automatic chk_active(input string tag);
    chk({tag, "_weights"}, layer_weights, flat_w());
    chk({tag, "_luts"}, lut_addrs, flat_a());
    chk({tag, "_pvalid"}, params_valid, exp_pv);
  endtask

  // One load attempt; last_at = word carrying s_last (-1 = none), abort_at = word aborted.
  task automatic run_load(input string tag, input int last_at, input int abort_at,
                          input bit toggle, input bit rnd, input logic [DW-1:0] base);
    int  k, cyc;
    bit  done, v, rdy, saw_commit, aborted, framed_bad;
    for (int n = 0; n < NWORDS; n++) words[n] = rnd ? DW'($urandom) : base + DW'(n);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk({tag, "_start_busy"}, load_busy, 1'b1);
    chk({tag, "_start_err_clr"}, load_error, 1'b0);
    k = 0; cyc = 0; done = 0; saw_commit = 0; aborted = 0; framed_bad = 0;
    while (!done && cyc < 400) begin
      v          = toggle ? (cyc % 2 == 0) : 1'b1;
      s_valid    = v;
      s_data     = words[k];
      s_last     = (k == last_at);
      load_abort = (k == abort_at) && v;
      rdy        = s_ready;
      @(posedge clk); #1;
      if (commit) saw_commit = 1;
      cyc++;
      if (v && rdy) begin
        if (load_abort) begin
          done = 1; aborted = 1;
        end else if (s_last || k == NWORDS - 1) begin
          done = 1;
          framed_bad = !(s_last && k == NWORDS - 1);
        end
        k++;
      end
      s_valid = 1'b0; s_last = 1'b0; load_abort = 1'b0;
    end
    if (!done) chk({tag, "_timeout"}, 1'b0, 1'b1);
    chk({tag, "_no_early_commit"}, saw_commit, 1'b0);
    if (!aborted && !framed_bad) begin
      chk({tag, "_commit_state_busy"}, load_busy, 1'b1);
      chk({tag, "_commit_not_yet"}, commit, 1'b0);
      @(posedge clk); #1;
      model_commit();
      chk({tag, "_commit_pulse"}, commit, 1'b1);
      chk({tag, "_busy_drop"}, load_busy, 1'b0);
      chk({tag, "_err"}, load_error, 1'b0);
      chk_active(tag);
      @(posedge clk); #1;
      chk({tag, "_commit_one_cycle"}, commit, 1'b0);
    end else begin
      chk({tag, "_err"}, load_error, framed_bad);
      chk({tag, "_idle_ready"}, s_ready, 1'b0);
      chk({tag, "_idle_busy"}, load_busy, 1'b0);
      saw_commit = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (commit) saw_commit = 1;
      end
      chk({tag, "_no_commit"}, saw_commit, 1'b0);
      chk_active(tag);
    end
  endtask

  initial begin
    rst = 1'b0; load_start = 1'b0; load_abort = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_weights", layer_weights, '0);
    chk("rst_luts", lut_addrs, '0);
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_flags", {params_valid, commit, load_busy, load_error}, 4'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", s_ready, 1'b0);

    run_load("seq", NWORDS - 1, -1, 1'b0, 1'b0, 16'h0100);
    chk("n0_weights", layer_weights[0 +: 4*DW], {16'h0103, 16'h0102, 16'h0101, 16'h0100});
    chk("n0_lut", lut_addrs[7:0], 8'h04);
    chk("n3_weights", layer_weights[12*DW +: 4*DW], {16'h0112, 16'h0111, 16'h0110, 16'h010F});
    chk("n3_lut", lut_addrs[31:24], 8'h13);

    run_load("toggle", NWORDS - 1, -1, 1'b1, 1'b0, 16'h0100);
    run_load("rnd_a", NWORDS - 1, -1, 1'b0, 1'b1, 16'h0);
    run_load("early_last", 10, -1, 1'b0, 1'b1, 16'h0);
    run_load("missing_last", -1, -1, 1'b0, 1'b1, 16'h0);
    run_load("recover", NWORDS - 1, -1, 1'b1, 1'b1, 16'h0);
    run_load("abort7", NWORDS - 1, 7, 1'b0, 1'b1, 16'h0);
    run_load("after_abort", NWORDS - 1, -1, 1'b0, 1'b1, 16'h0);
    chk("word7_new", layer_weights[6*DW +: DW], words[7]);

    // Asynchronous reset in the middle of word 12.
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int n = 0; n < 12; n++) begin
      s_valid = 1'b1; s_data = DW'($urandom); s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_data = DW'($urandom);
    #3 rst = 1'b0;
    #1;
    model_clear();
    chk("arst_weights", layer_weights, '0);
    chk("arst_luts", lut_addrs, '0);
    chk("arst_flags", {params_valid, commit, load_busy, load_error, s_ready}, 5'b0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_ready", s_ready, 1'b0);
    end
    chk_active("post_rst");
    run_load("post_rst_load", NWORDS - 1, -1, 1'b1, 1'b1, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
